// File: rtl/sha_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sha_round_ctrl
// Purpose  : Round sequencer for the shared SHA-256/384/512 compression core.
//            Accepts one block request at a time, latches the hash mode and
//            steps the even/odd K-ROM round indices two rounds per cycle.
//            It also issues the load, IV-init, schedule, digest and done
//            strobes.
// Revision : 1.0 - initial release
// ============================================================================
module sha_round_ctrl #(
    parameter logic SHA512_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic       hash_size_i,
    input  logic       first_block_i,
    input  logic       abort_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       hash_size_o,
    output logic [6:0] cnt_even_o,
    output logic [6:0] cnt_odd_o,
    output logic       load_blk_o,
    output logic       init_hv_o,
    output logic       round_en_o,
    output logic       sched_en_o,
    output logic       digest_add_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Even index of the last round pair for each mode.
    localparam logic [6:0] c_LAST_256  = 7'd62;
    localparam logic [6:0] c_LAST_512  = 7'd78;
    // Message schedule expansion starts at round 16.
    localparam logic [6:0] c_SCHED_BEG = 7'd16;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [6:0] r_cnt;
    logic [6:0] w_cnt_nxt;
    logic [6:0] w_last_cnt;
    logic       r_hash_size;
    logic       r_first_blk;
    logic       w_accept;
    logic       w_abortable;

    // Next-state and round-counter decode; abort overrides normal advance.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = 7'd0;
        w_accept    = 1'b0;
        w_last_cnt  = r_hash_size ? c_LAST_512 : c_LAST_256;
        w_abortable = (r_state == S_LOAD) || (r_state == S_ROUND) ||
                      (r_state == S_FINAL);

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_ROUND;
            end
            S_ROUND: begin
                // Counter saturates at the terminal pair; leaving ROUND
                // returns it to zero.
                if (r_cnt >= w_last_cnt) begin
                    w_state_nxt = S_FINAL;
                end else begin
                    w_cnt_nxt = r_cnt + 7'd2;
                end
            end
            S_FINAL: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (abort_i && w_abortable) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 7'd0;
        end
    end

    // State, round counter and per-block mode latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 7'd0;
            r_hash_size <= 1'b0;
            r_first_blk <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_hash_size <= hash_size_i & SHA512_EN;
                r_first_blk <= first_block_i;
            end
        end
    end

    // All outputs decode registered state only.
    assign ready_o      = (r_state == S_IDLE);
    assign busy_o       = (r_state == S_LOAD) || (r_state == S_ROUND) ||
                          (r_state == S_FINAL);
    assign hash_size_o  = r_hash_size;
    assign cnt_even_o   = r_cnt;
    assign cnt_odd_o    = r_cnt + 7'd1;
    assign load_blk_o   = (r_state == S_LOAD);
    assign init_hv_o    = (r_state == S_LOAD) && r_first_blk;
    assign round_en_o   = (r_state == S_ROUND);
    assign sched_en_o   = (r_state == S_ROUND) && (r_cnt >= c_SCHED_BEG);
    assign digest_add_o = (r_state == S_FINAL);
    assign done_o       = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_sha_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha_round_ctrl
// Purpose  : Directed self-checking bench for sha_round_ctrl. Two instances
//            share the stimulus: one with SHA-512 enabled, one forced to
//            SHA-256 only.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha_round_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_i = 1'b0;
    logic hash_size_i = 1'b0;
    logic first_block_i = 1'b0;
    logic abort_i = 1'b0;

    logic       ready_a, busy_a, hs_a, load_a, init_a, round_a, sched_a, dig_a, done_a;
    logic [6:0] ce_a, co_a;
    logic       ready_b, busy_b, hs_b, load_b, init_b, round_b, sched_b, dig_b, done_b;
    logic [6:0] ce_b, co_b;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    sha_round_ctrl #(.SHA512_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .hash_size_i(hash_size_i),
        .first_block_i(first_block_i), .abort_i(abort_i),
        .ready_o(ready_a), .busy_o(busy_a), .hash_size_o(hs_a),
        .cnt_even_o(ce_a), .cnt_odd_o(co_a), .load_blk_o(load_a),
        .init_hv_o(init_a), .round_en_o(round_a), .sched_en_o(sched_a),
        .digest_add_o(dig_a), .done_o(done_a)
    );

    sha_round_ctrl #(.SHA512_EN(1'b0)) dut256 (
        .clk(clk), .rst(rst), .start_i(start_i), .hash_size_i(hash_size_i),
        .first_block_i(first_block_i), .abort_i(abort_i),
        .ready_o(ready_b), .busy_o(busy_b), .hash_size_o(hs_b),
        .cnt_even_o(ce_b), .cnt_odd_o(co_b), .load_blk_o(load_b),
        .init_hv_o(init_b), .round_en_o(round_b), .sched_en_o(sched_b),
        .digest_add_o(dig_b), .done_o(done_b)
    );

    // Status vector: {ready, busy, load_blk, init_hv, round_en, sched_en, digest_add, done}
    wire [7:0] st_a = {ready_a, busy_a, load_a, init_a, round_a, sched_a, dig_a, done_a};
    wire [7:0] st_b = {ready_b, busy_b, load_b, init_b, round_b, sched_b, dig_b, done_b};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        nvec++;
        if ({st_a, hs_a, ce_a, co_a} !== {8'b1000_0000, 1'b0, 7'd0, 7'd1}) begin
            nerr++;
            $display("FAIL reset_a: got st=%b hs=%b cnt=%0d/%0d want st=10000000 hs=0 cnt=0/1", st_a, hs_a, ce_a, co_a);
        end
        nvec++;
        if ({st_b, hs_b, ce_b, co_b} !== {8'b1000_0000, 1'b0, 7'd0, 7'd1}) begin
            nerr++;
            $display("FAIL reset_b: got st=%b hs=%b cnt=%0d/%0d want st=10000000 hs=0 cnt=0/1", st_b, hs_b, ce_b, co_b);
        end
    endtask

    // Full block from accept to return of ready; sel256 picks the SHA-256-only
    // instance, hold keeps start_i high and toggles hash_size_i throughout.
    task automatic test_block(input logic hs, input logic fb, input logic exp_hs,
                              input int pairs, input bit sel256, input bit hold);
        logic [7:0] st;
        logic [7:0] exp_st;
        logic [6:0] ce, co;
        logic       ho;
        start_i = 1'b1;
        hash_size_i = hs;
        first_block_i = fb;
        tick();
        if (!hold) start_i = 1'b0;
        hash_size_i = ~hs;
        first_block_i = ~fb;
        st = sel256 ? st_b : st_a; ce = sel256 ? ce_b : ce_a;
        co = sel256 ? co_b : co_a; ho = sel256 ? hs_b : hs_a;
        exp_st = {1'b0, 1'b1, 1'b1, fb, 4'b0000};
        nvec++;
        if (st !== exp_st) begin
            nerr++;
            $display("FAIL load_state: got %b want %b", st, exp_st);
        end
        nvec++;
        if ({ho, ce, co} !== {exp_hs, 7'd0, 7'd1}) begin
            nerr++;
            $display("FAIL load_cnt: got hs=%b cnt=%0d/%0d want hs=%b cnt=0/1", ho, ce, co, exp_hs);
        end
        for (int i = 0; i < pairs; i++) begin
            if (hold) hash_size_i = ~hash_size_i;
            tick();
            st = sel256 ? st_b : st_a; ce = sel256 ? ce_b : ce_a;
            co = sel256 ? co_b : co_a; ho = sel256 ? hs_b : hs_a;
            exp_st = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, (i >= 8), 1'b0, 1'b0};
            nvec++;
            if (st !== exp_st) begin
                nerr++;
                $display("FAIL round_state[%0d]: got %b want %b", i, st, exp_st);
            end
            nvec++;
            if ({ho, ce, co} !== {exp_hs, 7'(2 * i), 7'(2 * i + 1)}) begin
                nerr++;
                $display("FAIL round_cnt[%0d]: got hs=%b cnt=%0d/%0d want hs=%b cnt=%0d/%0d",
                         i, ho, ce, co, exp_hs, 2 * i, 2 * i + 1);
            end
        end
        tick();
        st = sel256 ? st_b : st_a; ce = sel256 ? ce_b : ce_a; co = sel256 ? co_b : co_a;
        nvec++;
        if ({st, ce, co} !== {8'b0100_0010, 7'd0, 7'd1}) begin
            nerr++;
            $display("FAIL final: got st=%b cnt=%0d/%0d want st=01000010 cnt=0/1", st, ce, co);
        end
        tick();
        st = sel256 ? st_b : st_a;
        nvec++;
        if (st !== 8'b0000_0001) begin
            nerr++;
            $display("FAIL done: got %b want 00000001", st);
        end
        tick();
        st = sel256 ? st_b : st_a;
        nvec++;
        if (st !== 8'b1000_0000) begin
            nerr++;
            $display("FAIL ready_back: got %b want 10000000", st);
        end
    endtask

    task automatic test_start_held();
        test_block(1'b0, 1'b1, 1'b0, 32, 1'b0, 1'b1);
        // start_i still high while ready: a fresh accept happens now.
        tick();
        nvec++;
        if ((st_a & 8'b1110_0000) !== 8'b0110_0000) begin
            nerr++;
            $display("FAIL reaccept: got %b want 011xxxxx", st_a);
        end
        start_i = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        nvec++;
        if ({st_a, ce_a, co_a} !== {8'b1000_0000, 7'd0, 7'd1}) begin
            nerr++;
            $display("FAIL abort_load: got st=%b cnt=%0d/%0d want 10000000 0/1", st_a, ce_a, co_a);
        end
    endtask

    task automatic test_abort_round();
        bit seen;
        start_i = 1'b1; hash_size_i = 1'b0; first_block_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i <= 10; i++) tick();
        nvec++;
        if (ce_a !== 7'd20) begin
            nerr++;
            $display("FAIL abort_pre: got cnt=%0d want 20", ce_a);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        nvec++;
        if ({st_a, ce_a, co_a} !== {8'b1000_0000, 7'd0, 7'd1}) begin
            nerr++;
            $display("FAIL abort_round: got st=%b cnt=%0d/%0d want 10000000 0/1", st_a, ce_a, co_a);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dig_a || done_a || !ready_a) seen = 1'b1;
            tick();
        end
        nvec++;
        if (seen !== 1'b0) begin
            nerr++;
            $display("FAIL abort_quiet: got activity=%b want 0", seen);
        end
    endtask

    task automatic test_abort_final();
        start_i = 1'b1; hash_size_i = 1'b0; first_block_i = 1'b0;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 33; i++) tick();
        nvec++;
        if (dig_a !== 1'b1) begin
            nerr++;
            $display("FAIL abort_final_pre: got digest_add=%b want 1", dig_a);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        nvec++;
        if (st_a !== 8'b1000_0000) begin
            nerr++;
            $display("FAIL abort_final: got %b want 10000000", st_a);
        end
    endtask

    task automatic test_disabled();
        test_block(1'b1, 1'b1, 1'b0, 32, 1'b1, 1'b0);
        // The SHA-512 instance is still mid-block; clear it.
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_rst_mid();
        start_i = 1'b1; hash_size_i = 1'b1; first_block_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i <= 20; i++) tick();
        nvec++;
        if ({hs_a, ce_a} !== {1'b1, 7'd40}) begin
            nerr++;
            $display("FAIL rst_pre: got hs=%b cnt=%0d want hs=1 cnt=40", hs_a, ce_a);
        end
        rst = 1'b1;
        tick();
        nvec++;
        if ({st_a, hs_a, ce_a, co_a} !== {8'b1000_0000, 1'b0, 7'd0, 7'd1}) begin
            nerr++;
            $display("FAIL rst_mid: got st=%b hs=%b cnt=%0d/%0d want 10000000 0 0/1", st_a, hs_a, ce_a, co_a);
        end
        rst = 1'b0;
        start_i = 1'b1; hash_size_i = 1'b0; first_block_i = 1'b0;
        tick();
        start_i = 1'b0;
        nvec++;
        if ({st_a, hs_a} !== {8'b0110_0000, 1'b0}) begin
            nerr++;
            $display("FAIL rst_reaccept: got st=%b hs=%b want 01100000 0", st_a, hs_a);
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_block(1'b0, 1'b1, 1'b0, 32, 1'b0, 1'b0);   // SHA-256, first block
        test_block(1'b1, 1'b0, 1'b1, 40, 1'b0, 1'b0);   // SHA-512, continuation
        test_start_held();
        test_abort_round();
        test_abort_final();
        test_disabled();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
